reservation_station_n: RTL and testbench

RESERVATION_STATION_N -- requirements
Module: reservation_station_n

---
 rtl/reservation_station_n.sv | 210 +++++++++++++++++++++
 tb/tb_reservation_station_n.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station_n.sv
// Reservation station with age-ordered issue, multi-port CDB wakeup and alloc-time bypass.
// Entries leave the station when they move into the single issue output register.
module reservation_station_n #(
  parameter int DEPTH   = 16,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int TYPE_W  = 6,
  parameter int NUM_CDB = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [TYPE_W-1:0]          alloc_type,
  input  logic [DATA_W-1:0]          alloc_pc,
  input  logic [DATA_W-1:0]          alloc_imm,
  input  logic [TAG_W-1:0]           alloc_tag,
  input  logic [DATA_W-1:0]          alloc_vj,
  input  logic [DATA_W-1:0]          alloc_vk,
  input  logic [TAG_W-1:0]           alloc_qj,
  input  logic [TAG_W-1:0]           alloc_qk,
  input  logic                       alloc_qj_v,
  input  logic                       alloc_qk_v,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]  cdb_data,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [TYPE_W-1:0]          issue_type,
  output logic [DATA_W-1:0]          issue_vj,
  output logic [DATA_W-1:0]          issue_vk,
  output logic [DATA_W-1:0]          issue_pc,
  output logic [DATA_W-1:0]          issue_imm,
  output logic [TAG_W-1:0]           issue_tag,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]  busy, qj_v, qk_v;
  logic [TYPE_W-1:0] e_type [DEPTH];
  logic [DATA_W-1:0] e_pc   [DEPTH];
  logic [DATA_W-1:0] e_imm  [DEPTH];
  logic [TAG_W-1:0]  e_tag  [DEPTH];
  logic [DATA_W-1:0] e_vj   [DEPTH];
  logic [DATA_W-1:0] e_vk   [DEPTH];
  logic [TAG_W-1:0]  e_qj   [DEPTH];
  logic [TAG_W-1:0]  e_qk   [DEPTH];
  // older[j][i] set means entry j was allocated before entry i
  logic [DEPTH-1:0]  older  [DEPTH];
  logic [CW-1:0]     cnt;

  logic [DEPTH-1:0]  ready, blocked, wj_hit, wk_hit;
  logic [DATA_W-1:0] wj_data [DEPTH];
  logic [DATA_W-1:0] wk_data [DEPTH];
  logic              aj_hit, ak_hit;
  logic [DATA_W-1:0] aj_data, ak_data;
  logic [IW-1:0]     sel_idx, free_idx;
  logic              sel_any, acc, load;

  assign count       = cnt;
  assign ready       = busy & ~qj_v & ~qk_v;
  assign alloc_ready = rst & rdy & ~flush & (cnt < CW'(DEPTH));
  assign acc         = alloc_valid & alloc_ready;
  assign load        = sel_any & (~issue_valid | issue_ready);

  // Descending port scan so the lowest matching CDB port wins.
  always_comb begin
    wj_hit  = '0;
    wk_hit  = '0;
    aj_hit  = 1'b0;
    ak_hit  = 1'b0;
    aj_data = '0;
    ak_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wj_data[i] = '0;
      wk_data[i] = '0;
    end
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if (cdb_valid[p]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (cdb_tag[p*TAG_W +: TAG_W] == e_qj[i]) begin
            wj_hit[i]  = 1'b1;
            wj_data[i] = cdb_data[p*DATA_W +: DATA_W];
          end
          if (cdb_tag[p*TAG_W +: TAG_W] == e_qk[i]) begin
            wk_hit[i]  = 1'b1;
            wk_data[i] = cdb_data[p*DATA_W +: DATA_W];
          end
        end
        if (cdb_tag[p*TAG_W +: TAG_W] == alloc_qj) begin
          aj_hit  = 1'b1;
          aj_data = cdb_data[p*DATA_W +: DATA_W];
        end
        if (cdb_tag[p*TAG_W +: TAG_W] == alloc_qk) begin
          ak_hit  = 1'b1;
          ak_data = cdb_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    blocked  = '0;
    sel_any  = 1'b0;
    sel_idx  = '0;
    free_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ready[j] && older[j][i]) blocked[i] = 1'b1;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && !blocked[i]) begin
        sel_any = 1'b1;
        sel_idx = IW'(i);
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy        <= '0;
      qj_v        <= '0;
      qk_v        <= '0;
      cnt         <= '0;
      issue_valid <= 1'b0;
      issue_type  <= '0;
      issue_vj    <= '0;
      issue_vk    <= '0;
      issue_pc    <= '0;
      issue_imm   <= '0;
      issue_tag   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        older[i]  <= '0;
        e_type[i] <= '0;
        e_pc[i]   <= '0;
        e_imm[i]  <= '0;
        e_tag[i]  <= '0;
        e_vj[i]   <= '0;
        e_vk[i]   <= '0;
        e_qj[i]   <= '0;
        e_qk[i]   <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        busy        <= '0;
        qj_v        <= '0;
        qk_v        <= '0;
        cnt         <= '0;
        issue_valid <= 1'b0;
        issue_type  <= '0;
        issue_vj    <= '0;
        issue_vk    <= '0;
        issue_pc    <= '0;
        issue_imm   <= '0;
        issue_tag   <= '0;
        for (int i = 0; i < DEPTH; i++) older[i] <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (busy[i] && qj_v[i] && wj_hit[i]) begin
            qj_v[i] <= 1'b0;
            e_vj[i] <= wj_data[i];
          end
          if (busy[i] && qk_v[i] && wk_hit[i]) begin
            qk_v[i] <= 1'b0;
            e_vk[i] <= wk_data[i];
          end
        end
        if (load) begin
          busy[sel_idx] <= 1'b0;
          issue_valid   <= 1'b1;
          issue_type    <= e_type[sel_idx];
          issue_vj      <= e_vj[sel_idx];
          issue_vk      <= e_vk[sel_idx];
          issue_pc      <= e_pc[sel_idx];
          issue_imm     <= e_imm[sel_idx];
          issue_tag     <= e_tag[sel_idx];
        end else if (issue_valid && issue_ready) begin
          issue_valid <= 1'b0;
        end
        if (acc) begin
          busy[free_idx]   <= 1'b1;
          e_type[free_idx] <= alloc_type;
          e_pc[free_idx]   <= alloc_pc;
          e_imm[free_idx]  <= alloc_imm;
          e_tag[free_idx]  <= alloc_tag;
          e_qj[free_idx]   <= alloc_qj;
          e_qk[free_idx]   <= alloc_qk;
          qj_v[free_idx]   <= alloc_qj_v & ~aj_hit;
          qk_v[free_idx]   <= alloc_qk_v & ~ak_hit;
          e_vj[free_idx]   <= (alloc_qj_v && aj_hit) ? aj_data : alloc_vj;
          e_vk[free_idx]   <= (alloc_qk_v && ak_hit) ? ak_data : alloc_vk;
          older[free_idx]  <= '0;
          for (int j = 0; j < DEPTH; j++) begin
            if (IW'(j) != free_idx) older[j][free_idx] <= 1'b1;
          end
        end
        cnt <= cnt + CW'(acc) - CW'(load);
      end
    end
  end

endmodule

// File: tb/tb_reservation_station_n.sv
// Directed bench for reservation_station_n: issue latency, wakeup, age order, backpressure,
// full condition, flush, bypass, CDB priority, rdy freeze and async reset.
module tb_reservation_station_n;

  logic        clk, rst, rdy, flush;
  logic        alloc_valid, alloc_ready;
  logic [5:0]  alloc_type;
  logic [31:0] alloc_pc, alloc_imm, alloc_vj, alloc_vk;
  logic [3:0]  alloc_tag, alloc_qj, alloc_qk;
  logic        alloc_qj_v, alloc_qk_v;
  logic [2:0]  cdb_valid;
  logic [11:0] cdb_tag;
  logic [95:0] cdb_data;
  logic        issue_valid, issue_ready;
  logic [5:0]  issue_type;
  logic [31:0] issue_vj, issue_vk, issue_pc, issue_imm;
  logic [3:0]  issue_tag;
  logic [4:0]  count;

  int n_chk = 0;
  int n_bad = 0;

  reservation_station_n dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_type(alloc_type), .alloc_pc(alloc_pc), .alloc_imm(alloc_imm), .alloc_tag(alloc_tag),
    .alloc_vj(alloc_vj), .alloc_vk(alloc_vk), .alloc_qj(alloc_qj), .alloc_qk(alloc_qk),
    .alloc_qj_v(alloc_qj_v), .alloc_qk_v(alloc_qk_v),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_type(issue_type), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_pc(issue_pc), .issue_imm(issue_imm), .issue_tag(issue_tag),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [3:0] tag, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [3:0] qj, input logic qjv, input logic [3:0] qk, input logic qkv);
    alloc_valid = 1'b1;
    alloc_type  = 6'(tag);
    alloc_pc    = 32'h1000 + 32'(tag);
    alloc_imm   = 32'h0;
    alloc_tag   = tag;
    alloc_vj    = vj;
    alloc_vk    = vk;
    alloc_qj    = qj;
    alloc_qj_v  = qjv;
    alloc_qk    = qk;
    alloc_qk_v  = qkv;
  endtask

  task automatic no_alloc();
    alloc_valid = 1'b0;
    alloc_qj_v  = 1'b0;
    alloc_qk_v  = 1'b0;
  endtask

  task automatic cdb(input int p, input logic [3:0] t, input logic [31:0] d);
    cdb_valid[p]          = 1'b1;
    cdb_tag[p*4 +: 4]     = t;
    cdb_data[p*32 +: 32]  = d;
  endtask

  task automatic cdb_clear();
    cdb_valid = '0;
    cdb_tag   = '0;
    cdb_data  = '0;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; issue_ready = 1'b1;
    alloc_type = '0; alloc_pc = '0; alloc_imm = '0; alloc_tag = '0;
    alloc_vj = '0; alloc_vk = '0; alloc_qj = '0; alloc_qk = '0;
    no_alloc();
    cdb_clear();
    tick();
    tick();
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_alloc_ready", 64'(alloc_ready), 64'd0);
    rst = 1'b1;
    tick();
    chk("alloc_ready_idle", 64'(alloc_ready), 64'd1);

    // both operands ready: one cycle from acceptance to issue
    alloc(4'd3, 32'd5, 32'd7, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    no_alloc();
    chk("t1_count_after_alloc", 64'(count), 64'd1);
    chk("t1_not_yet_valid", 64'(issue_valid), 64'd0);
    tick();
    chk("t1_issue_valid", 64'(issue_valid), 64'd1);
    chk("t1_issue_tag", 64'(issue_tag), 64'd3);
    chk("t1_issue_vj", 64'(issue_vj), 64'd5);
    chk("t1_issue_vk", 64'(issue_vk), 64'd7);
    chk("t1_count_zero", 64'(count), 64'd0);
    tick();
    chk("t1_drained", 64'(issue_valid), 64'd0);

    // pending qj woken by CDB port 2
    alloc(4'd1, 32'd0, 32'd2, 4'd6, 1'b1, 4'd0, 1'b0);
    tick();
    no_alloc();
    tick();
    chk("t2_pending_no_issue", 64'(issue_valid), 64'd0);
    cdb(2, 4'd6, 32'hAB);
    tick();
    cdb_clear();
    chk("t2_wake_edge_no_issue", 64'(issue_valid), 64'd0);
    tick();
    chk("t2_issue_valid", 64'(issue_valid), 64'd1);
    chk("t2_issue_tag", 64'(issue_tag), 64'd1);
    chk("t2_issue_vj", 64'(issue_vj), 64'hAB);
    tick();

    // A pending in entry 0, B and C ready: order B, C, A
    alloc(4'd10, 32'd0, 32'd3, 4'd12, 1'b1, 4'd0, 1'b0);
    tick();
    alloc(4'd11, 32'd1, 32'd1, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    alloc(4'd13, 32'd2, 32'd2, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    no_alloc();
    chk("t3_first_B", 64'(issue_tag), 64'd11);
    cdb(0, 4'd12, 32'h77);
    tick();
    cdb_clear();
    chk("t3_second_C", 64'(issue_tag), 64'd13);
    tick();
    chk("t3_third_A", 64'(issue_tag), 64'd10);
    chk("t3_A_vj", 64'(issue_vj), 64'h77);
    chk("t3_count", 64'(count), 64'd0);
    tick();
    chk("t3_drained", 64'(issue_valid), 64'd0);

    // younger entry in lower slot must lose to older entry in higher slot
    issue_ready = 1'b0;
    alloc(4'd7, 32'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    alloc(4'd8, 32'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    chk("t3b_hold_H", 64'(issue_tag), 64'd7);
    alloc(4'd9, 32'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    no_alloc();
    chk("t3b_count2", 64'(count), 64'd2);
    chk("t3b_still_H", 64'(issue_tag), 64'd7);
    issue_ready = 1'b1;
    tick();
    chk("t3b_older_E", 64'(issue_tag), 64'd8);
    tick();
    chk("t3b_younger_F", 64'(issue_tag), 64'd9);
    tick();
    chk("t3b_drained", 64'(issue_valid), 64'd0);

    // fill every entry with a pending operand
    for (int i = 0; i < 16; i++) begin
      alloc(4'(i), 32'd0, 32'd0, 4'(i), 1'b1, 4'd0, 1'b0);
      tick();
    end
    no_alloc();
    chk("t4_full_count", 64'(count), 64'd16);
    chk("t4_full_alloc_ready", 64'(alloc_ready), 64'd0);
    cdb(0, 4'd5, 32'h5A);
    tick();
    cdb_clear();
    chk("t4_wake_still_full", 64'(alloc_ready), 64'd0);
    tick();
    chk("t4_issue_tag", 64'(issue_tag), 64'd5);
    chk("t4_count_15", 64'(count), 64'd15);
    chk("t4_alloc_ready_back", 64'(alloc_ready), 64'd1);

    // backpressure holds the payload, then flush clears everything
    issue_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_hold_valid", 64'(issue_valid), 64'd1);
    chk("t5_hold_tag", 64'(issue_tag), 64'd5);
    chk("t5_hold_vj", 64'(issue_vj), 64'h5A);
    chk("t5_hold_pc", 64'(issue_pc), 64'h1005);
    flush = 1'b1;
    #1;
    chk("t5_flush_alloc_ready", 64'(alloc_ready), 64'd0);
    tick();
    flush = 1'b0;
    issue_ready = 1'b1;
    chk("t5_flush_valid", 64'(issue_valid), 64'd0);
    chk("t5_flush_count", 64'(count), 64'd0);
    tick();
    chk("t5_no_stale_issue", 64'(issue_valid), 64'd0);

    // rdy low freezes state
    alloc(4'd12, 32'h99, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    no_alloc();
    rdy = 1'b0;
    #1;
    chk("t6_rdy_alloc_ready", 64'(alloc_ready), 64'd0);
    tick();
    tick();
    chk("t6_frozen_valid", 64'(issue_valid), 64'd0);
    chk("t6_frozen_count", 64'(count), 64'd1);
    rdy = 1'b1;
    tick();
    chk("t6_resume_tag", 64'(issue_tag), 64'd12);
    chk("t6_resume_vj", 64'(issue_vj), 64'h99);
    tick();

    // alloc-time bypass on qk
    alloc(4'd2, 32'd1, 32'd0, 4'd0, 1'b0, 4'd9, 1'b1);
    cdb(1, 4'd9, 32'h55);
    tick();
    no_alloc();
    cdb_clear();
    chk("t7_bypass_count", 64'(count), 64'd1);
    tick();
    chk("t7_bypass_valid", 64'(issue_valid), 64'd1);
    chk("t7_bypass_vk", 64'(issue_vk), 64'h55);
    tick();

    // same tag on several ports: lowest port supplies the data
    alloc(4'd3, 32'd0, 32'd0, 4'd4, 1'b1, 4'd0, 1'b0);
    tick();
    no_alloc();
    cdb(2, 4'd4, 32'h33);
    cdb(1, 4'd4, 32'h22);
    cdb(0, 4'd4, 32'h11);
    tick();
    cdb_clear();
    tick();
    chk("t8_prio_tag", 64'(issue_tag), 64'd3);
    chk("t8_prio_vj", 64'(issue_vj), 64'h11);
    tick();

    // async reset while an issue is held
    issue_ready = 1'b0;
    alloc(4'd7, 32'h42, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    tick();
    no_alloc();
    alloc(4'd6, 32'd0, 32'd0, 4'd1, 1'b1, 4'd0, 1'b0);
    tick();
    no_alloc();
    chk("t9_pre_rst_valid", 64'(issue_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t9_rst_valid", 64'(issue_valid), 64'd0);
    chk("t9_rst_tag", 64'(issue_tag), 64'd0);
    chk("t9_rst_vj", 64'(issue_vj), 64'd0);
    chk("t9_rst_count", 64'(count), 64'd0);
    chk("t9_rst_alloc_ready", 64'(alloc_ready), 64'd0);
    tick();
    rst = 1'b1;
    issue_ready = 1'b1;
    tick();
    chk("t9_post_rst_valid", 64'(issue_valid), 64'd0);
    chk("t9_post_rst_ready", 64'(alloc_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
